mat_mul_unit: RTL and testbench
===============================

// Module: mat_mul_unit
// PURPOSE
//  Responder side of the execute-stage matrix interface (start/WrEnA/B/C/row/col/data/done).
//  Holds three DIM x DIM word matrices A, B, C.
//  Accepts element writes, computes C = C + A*B on start, serves combinational element reads of C.
//  Sits under the execute stage. The stage holds start_i high and stalls until done_o pulses.
// PARAMETERS
//  DIM    4   matrix dimension; legal 1..32 (row/col are 5 bits)
//  DW     32  element and data-port width
// PORTS
//  clk_i       in   1    clock; all state updates on posedge
//  rst_n_i     in   1    reset, synchronous, active-low
//  start_i     in   1    request multiply-accumulate; held high by initiator until done_o
//  wr_en_a_i   in   1    write data_i to A[row_i][col_i]
//  wr_en_b_i   in   1    write data_i to B[row_i][col_i]
//  wr_en_c_i   in   1    write data_i to C[row_i][col_i] (preload/clear accumulator)
//  row_i       in   5    element row index
//  col_i       in   5    element column index
//  data_i      in   DW   write data (initiator's forwarded rs1 value)
//  data_o      out  DW   C[row_i][col_i], combinational; 0 if index >= DIM
//  done_o      out  1    one-cycle pulse: computation complete
//  busy_o      out  1    high in MAC and DONE states
// BEHAVIOUR
//  Reset (rst_n_i=0 at posedge):
//   - A, B, C cleared to 0; state=IDLE; i/j/k counters=0; done_o=0; busy_o=0.
//   - Reset mid-computation aborts the computation with the same result.
//  FSM states:
//   - IDLE: start_i=1 -> MAC (i=j=k=0); else stay.
//   - MAC: each cycle C[i][j] <= C[i][j] + A[i][k]*B[k][j].
//     k inner, j middle, i outer loop.
//     Last MAC is at i=j=k=DIM-1, after which the FSM moves to DONE.
//   - DONE: done_o=1 for exactly this cycle; -> IDLE unconditionally.
//     start_i still high here is ignored, so there is no retrigger.
//  Latency:
//   - start_i seen in IDLE at cycle t -> MAC cycles t+1..t+DIM^3.
//   - done_o=1 at cycle t+DIM^3+1 (65 for DIM=4).
//   - A new start_i in the IDLE cycle after DONE launches immediately (back-to-back instructions).
//  Arithmetic:
//   - Product is the low DW bits of A*B; accumulate wraps mod 2^DW.
//   - Two's-complement wrap, so the result is identical for signed and unsigned.
//  Writes:
//   - Accepted only in IDLE; ignored in MAC/DONE.
//   - Multiple wr_en_* in one cycle: each named matrix gets data_i.
//   - Index >= DIM: write dropped.
//   - Write and start in the same IDLE cycle: the write commits at that edge; the first MAC uses the updated value.
//  Reads:
//   - data_o is valid in every state.
//   - During MAC it shows the partial C.
// TESTING
//  T1 reset:
//   - Write A/B/C nonzero, pulse rst_n_i low 1 cycle.
//   - All reads =0, done_o=0, busy_o=0.
//  T2 identity:
//   - A=I, B[r][c]=4r+c, C=0, start_i held.
//   - done_o pulses exactly 65 cycles after start; C==B; busy_o low the cycle after.
//  T3 accumulate:
//   - Repeat T2 without clearing C.
//   - C[r][c]=2*(4r+c); then wr_en_c_i clears C[3][3] -> read 0.
//  T4 protocol:
//   - Hold start_i through DONE: no second run.
//   - Re-assert start_i in the next cycle: second done_o 65 cycles later.
//   - wr_en_a_i while busy: A unchanged.
//  T5 bounds:
//   - Write row_i=5: no matrix changes, read row 5 =0.
//   - A[0][0]=B[0][0]=0x0001_0000, others 0: C[0][0]=0 (wrap).
//   - A[0][0]=0xFFFF_FFFF, B[0][0]=2: C[0][0]=0xFFFF_FFFE.
//  T6 abort:
//   - Assert reset 10 cycles into MAC.
//   - All C reads 0, busy_o=0, no done_o; a fresh start completes normally.

Source files
------------

// File: rtl/mat_mul_unit.sv
// rtl/mat_mul_unit.sv - DIM x DIM matrix multiply-accumulate unit (C += A*B)
module mat_mul_unit #(
    parameter int DIM = 4,
    parameter int DW  = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          wr_en_a_i,
    input  logic          wr_en_b_i,
    input  logic          wr_en_c_i,
    input  logic [4:0]    row_i,
    input  logic [4:0]    col_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          done_o,
    output logic          busy_o
);

    localparam int            IW   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIM - 1);
    localparam logic [5:0]    DIM6 = 6'(DIM);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t        state;
    logic [DW-1:0] a_mat [DIM][DIM];
    logic [DW-1:0] b_mat [DIM][DIM];
    logic [DW-1:0] c_mat [DIM][DIM];
    logic [IW-1:0] i_q, j_q, k_q;
    logic [IW-1:0] row_idx, col_idx;
    logic          in_range;
    logic [DW-1:0] prod;

    assign in_range = ({1'b0, row_i} < DIM6) && ({1'b0, col_i} < DIM6);
    assign row_idx  = row_i[IW-1:0];
    assign col_idx  = col_i[IW-1:0];

    // Low DW bits only: the sum wraps identically for signed and unsigned operands.
    assign prod = a_mat[i_q][k_q] * b_mat[k_q][j_q];

    always_comb begin
        data_o = '0;
        if (in_range) begin
            data_o = c_mat[row_idx][col_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_mat[r][c] <= '0;
                    b_mat[r][c] <= '0;
                    c_mat[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_range) begin
                        if (wr_en_a_i) a_mat[row_idx][col_idx] <= data_i;
                        if (wr_en_b_i) b_mat[row_idx][col_idx] <= data_i;
                        if (wr_en_c_i) c_mat[row_idx][col_idx] <= data_i;
                    end
                    if (start_i) begin
                        state  <= MAC;
                        busy_o <= 1'b1;
                        i_q    <= '0;
                        j_q    <= '0;
                        k_q    <= '0;
                    end
                end
                MAC: begin
                    c_mat[i_q][j_q] <= c_mat[i_q][j_q] + prod;
                    // k innermost, then j, then i
                    if (k_q == LAST) begin
                        k_q <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q    <= '0;
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                i_q <= i_q + 1'b1;
                            end
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    // start_i is deliberately ignored here so a held request cannot retrigger
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mul_unit.sv
// tb/tb_mat_mul_unit.sv - scoreboard bench for mat_mul_unit
module tb_mat_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, wa, wb, wc;
    logic [4:0]  row, col;
    logic [31:0] data_in, data_out;
    logic        done, busy;

    always #5 clk = ~clk;

    mat_mul_unit #(.DIM(4), .DW(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .wr_en_a_i (wa),
        .wr_en_b_i (wb),
        .wr_en_c_i (wc),
        .row_i     (row),
        .col_i     (col),
        .data_i    (data_in),
        .data_o    (data_out),
        .done_o    (done),
        .busy_o    (busy)
    );

    typedef struct {
        string       name;
        int          kind;   // 0 data_o, 1 busy_o, 2 done_o
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   done_q[$];
    logic chk_vld = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations when a check is presented, and matches every done_o pulse
    always @(negedge clk) begin
        chk_t        e;
        logic [31:0] act;
        int          e_c;
        if (chk_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got check request, required a queued expectation");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       act = data_out;
                    1:       act = {31'b0, busy};
                    default: act = {31'b0, done};
                endcase
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h required 0x%08h", e.name, act, e.exp);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done_o=1 at cycle %0d, required none", cyc);
            end else begin
                e_c = done_q.pop_front();
                if (cyc != e_c) begin
                    errors++;
                    $display("FAIL done_latency: done_o at cycle %0d required cycle %0d", cyc, e_c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input int kind, input logic [31:0] e);
        chk_t t;
        t.name = nm;
        t.kind = kind;
        t.exp  = e;
        exp_q.push_back(t);
    endtask

    task automatic req(input string nm, input int kind, input logic [31:0] e,
                       input logic [4:0] r, input logic [4:0] c);
        push_exp(nm, kind, e);
        row     = r;
        col     = c;
        chk_vld = 1'b1;
        tick();
        chk_vld = 1'b0;
    endtask

    task automatic wr(input logic ea, input logic eb, input logic ec,
                      input logic [4:0] r, input logic [4:0] c, input logic [31:0] d);
        wa = ea; wb = eb; wc = ec;
        row = r; col = c; data_in = d;
        tick();
        wa = 1'b0; wb = 1'b0; wc = 1'b0;
    endtask

    task automatic load_ident_b();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                wr(1'b1, 1'b0, 1'b0, 5'(r), 5'(c), (r == c) ? 32'd1 : 32'd0);
                wr(1'b0, 1'b1, 1'b0, 5'(r), 5'(c), 32'(4 * r + c));
            end
        end
    endtask

    task automatic check_c(input string nm, input int mult);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                req($sformatf("%s_c%0d%0d", nm, r, c), 0, 32'(mult * (4 * r + c)), 5'(r), 5'(c));
            end
        end
    endtask

    // Holds start_i through the DONE edge (and through a second run when b2b)
    task automatic run_mac(input bit b2b, input bit busy_wr);
        int laps;
        laps  = b2b ? 2 : 1;
        start = 1'b1;
        done_q.push_back(cyc + 65);
        if (b2b) done_q.push_back(cyc + 131);
        for (int l = 0; l < laps; l++) begin
            for (int n = 0; n < 66; n++) begin
                tick();
                chk_vld = 1'b0;
                wa      = 1'b0;
                if (n == 30) begin
                    push_exp($sformatf("busy_mid_run%0d", l), 1, 32'd1);
                    chk_vld = 1'b1;
                end
                if (busy_wr && l == 0 && n == 2) begin
                    wa = 1'b1; row = 5'd0; col = 5'd0; data_in = 32'd7;
                end
            end
        end
        push_exp("busy_after_done", 1, 32'd0);
        chk_vld = 1'b1;
        start   = 1'b0;
        tick();
        chk_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        wa = 1'b0; wb = 1'b0; wc = 1'b0;
        row = '0; col = '0; data_in = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // T1 reset clears everything
        wr(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5);
        wr(1'b0, 1'b1, 1'b0, 5'd1, 5'd1, 32'd6);
        wr(1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 32'd9);
        req("t1_pre_c23", 0, 32'd9, 5'd2, 5'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_c("t1", 0);
        req("t1_done", 2, 32'd0, 5'd0, 5'd0);
        req("t1_busy", 1, 32'd0, 5'd0, 5'd0);

        // T2 identity
        load_ident_b();
        run_mac(1'b0, 1'b0);
        check_c("t2", 1);

        // T3 accumulate, then clear one element
        run_mac(1'b0, 1'b0);
        check_c("t3", 2);
        wr(1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 32'd0);
        req("t3_c33_clr", 0, 32'd0, 5'd3, 5'd3);

        // T4 back-to-back runs, then writes ignored while busy
        wr(1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 32'd30);
        run_mac(1'b1, 1'b0);
        check_c("t4_b2b", 4);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr(1'b0, 1'b0, 1'b1, 5'(r), 5'(c), 32'd0);
        run_mac(1'b0, 1'b1);
        check_c("t4_busy_wr", 1);

        // T5 out-of-range writes dropped, wrap-around arithmetic
        wr(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 32'hdead_beef);
        wr(1'b1, 1'b1, 1'b1, 5'd1, 5'd5, 32'hdead_beef);
        req("t5_row5", 0, 32'd0, 5'd5, 5'd0);
        req("t5_col5", 0, 32'd0, 5'd1, 5'd5);
        req("t5_c10", 0, 32'd4, 5'd1, 5'd0);
        req("t5_c11", 0, 32'd5, 5'd1, 5'd1);
        run_mac(1'b0, 1'b0);
        check_c("t5_bounds", 2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr(1'b1, 1'b1, 1'b1, 5'(r), 5'(c), 32'd0);
        wr(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0001_0000);
        run_mac(1'b0, 1'b0);
        req("t5_wrap_zero", 0, 32'd0, 5'd0, 5'd0);
        wr(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'hffff_ffff);
        wr(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'd2);
        run_mac(1'b0, 1'b0);
        req("t5_wrap_neg", 0, 32'hffff_fffe, 5'd0, 5'd0);

        // T6 reset mid-computation aborts
        load_ident_b();
        start = 1'b1;
        repeat (11) tick();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        req("t6_busy", 1, 32'd0, 5'd0, 5'd0);
        check_c("t6_abort", 0);
        repeat (70) tick();
        load_ident_b();
        run_mac(1'b0, 1'b0);
        check_c("t6_fresh", 1);

        repeat (3) tick();
        while (done_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_done: no done_o seen, required one at cycle %0d", done_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
